// File: rtl/tawas_rcn_master.sv
// RCN ring master for the Tawas load/store unit: queues requests, injects them
// into free ring slots, and pulls this master's responses off the ring.
module tawas_rcn_master #(
  parameter logic [5:0] MASTER_ID = 6'd0,
  parameter int         DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rcn_cs,
  input  logic        rcn_xch,
  input  logic        rcn_wr,
  input  logic [31:0] rcn_addr,
  input  logic [2:0]  rcn_wbreg,
  input  logic [3:0]  rcn_mask,
  input  logic [31:0] rcn_wdata,
  output logic        rcn_full,
  output logic        rcn_pending,
  output logic        rcn_ovf,
  input  logic [79:0] ring_in,
  output logic [79:0] ring_out,
  output logic        rcn_load_vld,
  output logic [2:0]  rcn_load_sel,
  output logic [31:0] rcn_load
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 71;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Entry layout: {xch, wr, wbreg, mask, addr[31:2], wdata}
  logic [EW-1:0] r_fifo [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [CW-1:0] r_outst;
  logic [79:0]   r_ring_out;
  logic          r_load_vld;
  logic [2:0]    r_load_sel;
  logic [31:0]   r_load;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_consume;
  logic          w_inject;
  logic          w_resp_rd;
  logic [EW-1:0] w_head;
  logic [79:0]   w_inj_pkt;
  logic [31:0]   w_aligned;
  logic          w_unused;

  assign w_unused = ^{rcn_addr[1:0], ring_in[62]};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = rcn_cs && !w_full;

  assign w_consume = ring_in[79] && !ring_in[78] && (ring_in[75:70] == MASTER_ID);
  assign w_resp_rd = w_consume && (!ring_in[77] || ring_in[76]);
  assign w_inject  = !ring_in[79] && !w_empty && (r_outst < CNT_MAX);

  assign w_head    = r_fifo[r_rptr[AW-1:0]];
  assign w_inj_pkt = {1'b1, 1'b1, w_head[69], w_head[70], MASTER_ID,
                      w_head[68:66], w_head[65:62], 1'b0, w_head[61:0]};

  always_comb begin
    w_aligned = ring_in[31:0];
    case (ring_in[66:63])
      4'b0011: w_aligned = {16'h0, ring_in[15:0]};
      4'b1100: w_aligned = {16'h0, ring_in[31:16]};
      4'b0001: w_aligned = {24'h0, ring_in[7:0]};
      4'b0010: w_aligned = {24'h0, ring_in[15:8]};
      4'b0100: w_aligned = {24'h0, ring_in[23:16]};
      4'b1000: w_aligned = {24'h0, ring_in[31:24]};
      default: w_aligned = ring_in[31:0];
    endcase
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr[AW-1:0]] <= {rcn_xch, rcn_wr, rcn_wbreg, rcn_mask,
                                 rcn_addr[31:2], rcn_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_outst    <= '0;
      r_ring_out <= '0;
      r_load_vld <= 1'b0;
      r_load_sel <= '0;
      r_load     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_inject)
        r_rptr <= r_rptr + PTR_ONE;

      // Consume and inject are exclusive: one needs a valid slot, the other an empty one.
      if (w_inject)
        r_outst <= r_outst + CNT_ONE;
      else if (w_consume && r_outst != '0)
        r_outst <= r_outst - CNT_ONE;

      if (w_consume)
        r_ring_out <= '0;
      else if (ring_in[79])
        r_ring_out <= ring_in;
      else if (w_inject)
        r_ring_out <= w_inj_pkt;
      else
        r_ring_out <= '0;

      r_load_vld <= w_resp_rd;
      if (w_resp_rd) begin
        r_load_sel <= ring_in[69:67];
        r_load     <= w_aligned;
      end

      if (rcn_cs && w_full)
        r_ovf <= 1'b1;
    end
  end

  assign rcn_full     = w_full;
  assign rcn_pending  = !w_empty || (r_outst != '0);
  assign rcn_ovf      = r_ovf;
  assign ring_out     = r_ring_out;
  assign rcn_load_vld = r_load_vld;
  assign rcn_load_sel = r_load_sel;
  assign rcn_load     = r_load;

endmodule

// File: tb/tb_tawas_rcn_master.sv
// Directed bench for tawas_rcn_master: per-cycle vector table plus hand-written
// sequences for FIFO fill/overflow, outstanding cap, simultaneous events and reset.
module tb_tawas_rcn_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcn_cs, rcn_xch, rcn_wr;
  logic [31:0] rcn_addr;
  logic [2:0]  rcn_wbreg;
  logic [3:0]  rcn_mask;
  logic [31:0] rcn_wdata;
  logic        rcn_full, rcn_pending, rcn_ovf;
  logic [79:0] ring_in, ring_out;
  logic        rcn_load_vld;
  logic [2:0]  rcn_load_sel;
  logic [31:0] rcn_load;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  tawas_rcn_master dut (
    .clk(clk), .rst(rst),
    .rcn_cs(rcn_cs), .rcn_xch(rcn_xch), .rcn_wr(rcn_wr),
    .rcn_addr(rcn_addr), .rcn_wbreg(rcn_wbreg), .rcn_mask(rcn_mask),
    .rcn_wdata(rcn_wdata),
    .rcn_full(rcn_full), .rcn_pending(rcn_pending), .rcn_ovf(rcn_ovf),
    .ring_in(ring_in), .ring_out(ring_out),
    .rcn_load_vld(rcn_load_vld), .rcn_load_sel(rcn_load_sel), .rcn_load(rcn_load)
  );

  typedef struct {
    string       name;
    logic        cs, xch, wr;
    logic [31:0] addr;
    logic [2:0]  wbreg;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [79:0] rin;
    logic [79:0] exp_out;
    logic        exp_vld;
    logic [2:0]  exp_sel;
    logic [31:0] exp_load;
    logic        exp_full;
    logic        exp_pend;
  } vec_t;

  vec_t tv[$];

  function automatic logic [79:0] mk(logic v, logic rq, logic wr, logic xch,
                                     logic [5:0] id, logic [2:0] wb, logic [3:0] m,
                                     logic [29:0] a, logic [31:0] d);
    return {v, rq, wr, xch, id, wb, m, 1'b0, a, d};
  endfunction

  // Foreign traffic from master 9; rq=0 makes it a response for someone else.
  function automatic logic [79:0] fr(int k, logic rq);
    return mk(1'b1, rq, 1'b0, 1'b0, 6'd9, 3'd0, 4'hF, 30'(k), 32'hF00D_0000 | 32'(k));
  endfunction

  function automatic vec_t vec(string nm, logic cs, logic xch, logic wr,
                               logic [31:0] addr, logic [2:0] wb, logic [3:0] m,
                               logic [31:0] wd, logic [79:0] rin, logic [79:0] eo,
                               logic ev, logic [2:0] es, logic [31:0] el,
                               logic ef, logic ep);
    vec_t t;
    t.name = nm; t.cs = cs; t.xch = xch; t.wr = wr; t.addr = addr; t.wbreg = wb;
    t.mask = m; t.wdata = wd; t.rin = rin; t.exp_out = eo; t.exp_vld = ev;
    t.exp_sel = es; t.exp_load = el; t.exp_full = ef; t.exp_pend = ep;
    return t;
  endfunction

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic cs, logic xch, logic wr, logic [31:0] addr,
                       logic [2:0] wb, logic [3:0] m, logic [31:0] wd, logic [79:0] rin);
    rcn_cs = cs; rcn_xch = xch; rcn_wr = wr; rcn_addr = addr;
    rcn_wbreg = wb; rcn_mask = m; rcn_wdata = wd; ring_in = rin;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0);
  endtask

  initial begin
    int ninj;
    logic [79:0] wr_rsp;

    // Table: inputs before the edge, expectations sampled after it.
    tv.push_back(vec("ld_enq", 1,0,0, 32'h8000_0104, 3'd5, 4'b0100, 32'h0, 80'h0,
                     80'h0, 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("ld_inject", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,0,0,6'd0,3'd5,4'b0100,30'h2000_0041,32'h0), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("ld_resp", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,0,0,6'd0,3'd5,4'b0100,30'h2000_0041,32'hAABB_CCDD),
                     80'h0, 1, 3'd5, 32'h0000_00BB, 0, 0));
    tv.push_back(vec("ld_quiet", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     80'h0, 0, 3'd0, 32'h0, 0, 0));
    tv.push_back(vec("wr_enq", 1,0,1, 32'h0000_0010, 3'd2, 4'hF, 32'h1234_5678, 80'h0,
                     80'h0, 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("wr_inject", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,1,0,6'd0,3'd2,4'hF,30'h4,32'h1234_5678), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("wr_resp", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,1,0,6'd0,3'd2,4'hF,30'h4,32'h1234_5678),
                     80'h0, 0, 3'd0, 32'h0, 0, 0));
    tv.push_back(vec("busy1", 1,0,0, 32'h0000_0100, 3'd1, 4'b0011, 32'h0, fr(1,1),
                     fr(1,1), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy2", 1,0,0, 32'h0000_0200, 3'd3, 4'b1000, 32'h0, fr(2,1),
                     fr(2,1), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy3_foreign_rsp", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, fr(3,0),
                     fr(3,0), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy4", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, fr(4,1),
                     fr(4,1), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy5", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, fr(5,1),
                     fr(5,1), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy6", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, fr(6,1),
                     fr(6,1), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy_injA", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,0,0,6'd0,3'd1,4'b0011,30'h40,32'h0), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy_injB", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,0,0,6'd0,3'd3,4'b1000,30'h80,32'h0), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("busy_rspA", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,0,0,6'd0,3'd1,4'b0011,30'h40,32'h1122_3344),
                     80'h0, 1, 3'd1, 32'h0000_3344, 0, 1));
    tv.push_back(vec("busy_rspB", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,0,0,6'd0,3'd3,4'b1000,30'h80,32'h9988_7766),
                     80'h0, 1, 3'd3, 32'h0000_0099, 0, 0));
    tv.push_back(vec("xch_enq", 1,1,1, 32'h0000_0FF0, 3'd6, 4'b0010, 32'hDEAD_BEEF, 80'h0,
                     80'h0, 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("xch_inject", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,1,1,6'd0,3'd6,4'b0010,30'h3FC,32'hDEAD_BEEF), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("xch_resp", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,1,1,6'd0,3'd6,4'b0010,30'h3FC,32'hCAFE_F00D),
                     80'h0, 1, 3'd6, 32'h0000_00F0, 0, 0));
    tv.push_back(vec("odd_enq", 1,0,0, 32'h0000_0004, 3'd7, 4'b0101, 32'h0, 80'h0,
                     80'h0, 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("odd_inject", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0, 80'h0,
                     mk(1,1,0,0,6'd0,3'd7,4'b0101,30'h1,32'h0), 0, 3'd0, 32'h0, 0, 1));
    tv.push_back(vec("odd_resp", 0,0,0, 32'h0, 3'd0, 4'h0, 32'h0,
                     mk(1,0,0,0,6'd0,3'd7,4'b0101,30'h1,32'h0102_0304),
                     80'h0, 1, 3'd7, 32'h0102_0304, 0, 0));

    // Reset
    idle();
    rst = 1'b0;
    step(); step();
    chk("rst_ring_out", ring_out, 80'h0);
    chk("rst_load_vld", 80'(rcn_load_vld), 80'h0);
    chk("rst_load_sel", 80'(rcn_load_sel), 80'h0);
    chk("rst_load", 80'(rcn_load), 80'h0);
    chk("rst_full", 80'(rcn_full), 80'h0);
    chk("rst_pending", 80'(rcn_pending), 80'h0);
    chk("rst_ovf", 80'(rcn_ovf), 80'h0);
    rst = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].cs, tv[i].xch, tv[i].wr, tv[i].addr, tv[i].wbreg,
            tv[i].mask, tv[i].wdata, tv[i].rin);
      step();
      chk({tv[i].name, "_out"}, ring_out, tv[i].exp_out);
      chk({tv[i].name, "_vld"}, 80'(rcn_load_vld), 80'(tv[i].exp_vld));
      if (tv[i].exp_vld) begin
        chk({tv[i].name, "_sel"}, 80'(rcn_load_sel), 80'(tv[i].exp_sel));
        chk({tv[i].name, "_load"}, 80'(rcn_load), 80'(tv[i].exp_load));
      end
      chk({tv[i].name, "_full"}, 80'(rcn_full), 80'(tv[i].exp_full));
      chk({tv[i].name, "_pend"}, 80'(rcn_pending), 80'(tv[i].exp_pend));
      chk({tv[i].name, "_ovf"}, 80'(rcn_ovf), 80'h0);
    end

    // Fill the FIFO against a saturated ring, then overflow it.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 4), 3'(i), 4'hF, 32'(i), fr(10 + i, 1));
      step();
      chk("fill_pass", ring_out, fr(10 + i, 1));
      chk("fill_full", 80'(rcn_full), 80'(i == 3));
    end
    drive(1'b1, 1'b0, 1'b1, 32'h1010, 3'd4, 4'hF, 32'd4, fr(14, 1));
    step();
    chk("ovf_set", 80'(rcn_ovf), 80'h1);
    chk("ovf_full", 80'(rcn_full), 80'h1);
    idle();
    ninj = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ring_out[79]) begin
        chk("fill_inj_order", 80'(ring_out[69:67]), 80'(ninj));
        ninj++;
      end
    end
    chk("fill_inj_count", 80'(ninj), 80'd4);
    chk("fill_drained", 80'(rcn_full), 80'h0);

    // Outstanding is at DEPTH: a new request must wait for a response.
    drive(1'b1, 1'b0, 1'b1, 32'h2000, 3'd5, 4'hF, 32'h55, 80'h0);
    step();
    idle();
    step();
    chk("cap_hold1", ring_out, 80'h0);
    step();
    chk("cap_hold2", ring_out, 80'h0);
    wr_rsp = mk(1,0,1,0,6'd0,3'd0,4'hF,30'h400,32'h0);
    ring_in = wr_rsp;
    step();
    chk("cap_consume", ring_out, 80'h0);
    chk("cap_consume_vld", 80'(rcn_load_vld), 80'h0);
    idle();
    step();
    chk("cap_release", ring_out, mk(1,1,1,0,6'd0,3'd5,4'hF,30'h800,32'h55));
    for (int i = 0; i < 4; i++) begin
      ring_in = wr_rsp;
      step();
    end
    idle();
    step();
    chk("cap_pend_clear", 80'(rcn_pending), 80'h0);
    chk("ovf_sticky", 80'(rcn_ovf), 80'h1);

    // Response arrives on the same edge as an enqueue with the FIFO non-empty.
    drive(1'b1, 1'b0, 1'b0, 32'h3000, 3'd1, 4'hF, 32'h0, 80'h0);
    step();
    idle();
    step();
    chk("sim_injX", ring_out, mk(1,1,0,0,6'd0,3'd1,4'hF,30'hC00,32'h0));
    drive(1'b1, 1'b0, 1'b0, 32'h3004, 3'd2, 4'hF, 32'h0, fr(20, 1));
    step();
    chk("sim_passY", ring_out, fr(20, 1));
    drive(1'b1, 1'b0, 1'b0, 32'h3008, 3'd3, 4'hF, 32'h0,
          mk(1,0,0,0,6'd0,3'd1,4'hF,30'hC00,32'h7777_8888));
    step();
    chk("sim_consume_out", ring_out, 80'h0);
    chk("sim_consume_vld", 80'(rcn_load_vld), 80'h1);
    chk("sim_consume_load", 80'(rcn_load), 80'h7777_8888);
    chk("sim_pend", 80'(rcn_pending), 80'h1);
    idle();
    step();
    chk("sim_injY", ring_out, mk(1,1,0,0,6'd0,3'd2,4'hF,30'hC01,32'h0));
    chk("sim_vld_drop", 80'(rcn_load_vld), 80'h0);
    step();
    chk("sim_injZ", ring_out, mk(1,1,0,0,6'd0,3'd3,4'hF,30'hC02,32'h0));
    step();
    chk("sim_fifo_empty", ring_out, 80'h0);
    ring_in = mk(1,0,0,0,6'd0,3'd2,4'hF,30'hC01,32'h1);
    step();
    ring_in = mk(1,0,0,0,6'd0,3'd3,4'hF,30'hC02,32'h2);
    step();
    chk("sim_pend_clear", 80'(rcn_pending), 80'h1 - 80'h1);

    // Reset mid-operation, then a stale response still writes back.
    idle();
    rcn_cs = 1'b1; rcn_addr = 32'h4000; rcn_wbreg = 3'd4; rcn_mask = 4'h1;
    step();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_pend", 80'(rcn_pending), 80'h0);
    chk("mid_rst_ovf", 80'(rcn_ovf), 80'h0);
    chk("mid_rst_out", ring_out, 80'h0);
    ring_in = mk(1,0,0,0,6'd0,3'd4,4'b0001,30'h1000,32'h1234_56CD);
    step();
    idle();
    chk("stale_vld", 80'(rcn_load_vld), 80'h1);
    chk("stale_sel", 80'(rcn_load_sel), 80'h4);
    chk("stale_load", 80'(rcn_load), 80'h0000_00CD);
    chk("stale_out", ring_out, 80'h0);
    step();
    chk("stale_pend", 80'(rcn_pending), 80'h0);
    chk("stale_no_inject", ring_out, 80'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
